pkt_serializer: RTL and testbench

Node-side transmit stage that feeds a router input port. Accepts whole 32-bit pkt_t packets from the node's packet source, queues them, and serializes each one into four consecutive 8-bit payload beats on the put/payload link. The far end of that link is a router in_buffer, whose free_inbound signal drives free_out. A packet starts only when free_out permits it. Once started, a packet is never interrupted.

---
 rtl/pkt_serializer.sv | 113 +++++++++++
 tb/tb_pkt_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_serializer.sv
// Node-side transmit stage: queues 32-bit packets and serializes each into
// four 8-bit beats on the put/payload link, gated by the router's free signal.
`timescale 1ns/1ps
module pkt_serializer #(
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [31:0]                pkt_in,
  input  logic                       pkt_in_avail,
  output logic                       pkt_in_read,
  input  logic                       free_out,
  output logic                       put_out,
  output logic [7:0]                 payload_out,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   sreg_q, sreg_d;
  logic          put_d;
  logic [7:0]    payload_d;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop, can_start, in_gap;

  function automatic logic [7:0] pick(input logic [31:0] p, input logic [1:0] k);
    logic [1:0] s;
    s = (MSB_FIRST != 0) ? ~k : k;
    case (s)
      2'd0:    pick = p[7:0];
      2'd1:    pick = p[15:8];
      2'd2:    pick = p[23:16];
      default: pick = p[31:24];
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count == CW'(DEPTH));
  assign pkt_in_read = pkt_in_avail && !full && !rst_b;
  assign push        = pkt_in_read;
  assign busy        = (state_q == SEND);

  // A new packet may start from IDLE or in the cycle carrying beat 3
  // (idx wrapped to 0), which gives gapless back-to-back packets.
  assign can_start = (count != '0) && free_out;
  assign in_gap    = (state_q == IDLE) || (idx_q == 2'd0);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sreg_d    = sreg_q;
    put_d     = 1'b0;
    payload_d = '0;
    pop       = 1'b0;
    if (in_gap && can_start) begin
      pop       = 1'b1;
      sreg_d    = mem[rd_ptr];
      put_d     = 1'b1;
      payload_d = pick(mem[rd_ptr], 2'd0);
      state_d   = SEND;
      idx_d     = 2'd1;
    end else if (state_q == SEND && idx_q != 2'd0) begin
      put_d     = 1'b1;
      payload_d = pick(sreg_q, idx_q);
      idx_d     = idx_q + 2'd1;
    end else begin
      state_d = IDLE;
      idx_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sreg_q      <= '0;
      put_out     <= 1'b0;
      payload_out <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sreg_q      <= sreg_d;
      put_out     <= put_d;
      payload_out <= payload_d;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt_in;
  end

endmodule

// File: tb/tb_pkt_serializer.sv
// Scoreboard bench for pkt_serializer: one MSB-first and one LSB-first instance
// share stimulus; monitors pop expected beats whenever put_out is high.
`timescale 1ns/1ps
module tb_pkt_serializer;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] pkt_in;
  logic        pkt_in_avail, free_out;
  logic        read_m, put_m, busy_m, read_l, put_l, busy_l;
  logic [7:0]  pay_m, pay_l;
  logic [2:0]  cnt_m, cnt_l;

  int tests = 0;
  int fails = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  pkt_serializer #(.DEPTH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_b(rst_b), .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail),
    .pkt_in_read(read_m), .free_out(free_out), .put_out(put_m),
    .payload_out(pay_m), .busy(busy_m), .count(cnt_m));

  pkt_serializer #(.DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_b(rst_b), .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail),
    .pkt_in_read(read_l), .free_out(free_out), .put_out(put_l),
    .payload_out(pay_l), .busy(busy_l), .count(cnt_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [31:0] am, input logic [31:0] al,
                      input logic [31:0] exp);
    chk({name, "_msb"}, am, exp);
    chk({name, "_lsb"}, al, exp);
  endtask

  task automatic expect_pkt(input logic [31:0] p);
    q_m.push_back(p[31:24]); q_m.push_back(p[23:16]);
    q_m.push_back(p[15:8]);  q_m.push_back(p[7:0]);
    q_l.push_back(p[7:0]);   q_l.push_back(p[15:8]);
    q_l.push_back(p[23:16]); q_l.push_back(p[31:24]);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // offer a packet for one cycle and check the hand-computed accept decision
  task automatic offer(input logic [31:0] p, input logic exp_read);
    pkt_in = p;
    pkt_in_avail = 1'b1;
    if (exp_read) expect_pkt(p);
    @(negedge clk);
    chk2("pkt_in_read", read_m, read_l, {31'd0, exp_read});
    nxt();
  endtask

  always @(negedge clk) begin
    if (!rst_b) begin
      if (put_m) begin
        if (q_m.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat_msb: got unexpected beat %h expected none at %0t", pay_m, $time);
        end else chk("beat_msb", {24'd0, pay_m}, {24'd0, q_m.pop_front()});
      end else chk("idle_payload_msb", {24'd0, pay_m}, 32'd0);
      if (put_l) begin
        if (q_l.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat_lsb: got unexpected beat %h expected none at %0t", pay_l, $time);
        end else chk("beat_lsb", {24'd0, pay_l}, {24'd0, q_l.pop_front()});
      end else chk("idle_payload_lsb", {24'd0, pay_l}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] fp [6];

  initial begin
    rst_b = 1'b1; pkt_in = 32'h0; pkt_in_avail = 1'b1; free_out = 1'b0;
    #2;
    chk2("rst_put", put_m, put_l, 0);
    chk2("rst_payload", pay_m, pay_l, 0);
    chk2("rst_busy", busy_m, busy_l, 0);
    chk2("rst_count", cnt_m, cnt_l, 0);
    chk2("rst_read", read_m, read_l, 0);
    pkt_in_avail = 1'b0;
    nxt(); nxt();
    rst_b = 1'b0;

    // single packet, latency c+2..c+5
    free_out = 1'b1;
    offer(32'h12345678, 1'b1);
    pkt_in_avail = 1'b0;
    @(negedge clk);
    chk2("lat_put_c1", put_m, put_l, 0);
    chk2("lat_count_c1", cnt_m, cnt_l, 1);
    nxt();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk2("single_put", put_m, put_l, 1);
      chk2("single_busy", busy_m, busy_l, 1);
      chk2("single_count", cnt_m, cnt_l, 0);
      nxt();
    end
    @(negedge clk);
    chk2("single_end_put", put_m, put_l, 0);
    chk2("single_end_busy", busy_m, busy_l, 0);
    nxt();

    // backpressure: A sends fully, B held until free_out returns
    free_out = 1'b0;
    offer(32'hA1A2A3A4, 1'b1);
    offer(32'hB1B2B3B4, 1'b1);
    pkt_in_avail = 1'b0;
    @(negedge clk);
    chk2("bp_count", cnt_m, cnt_l, 2);
    chk2("bp_put", put_m, put_l, 0);
    nxt();
    @(negedge clk); nxt();
    free_out = 1'b1;
    @(negedge clk); nxt();
    @(negedge clk);
    chk2("bp_a_beat0", put_m, put_l, 1);
    chk2("bp_a_count", cnt_m, cnt_l, 1);
    nxt();
    free_out = 1'b0;
    @(negedge clk); nxt();
    @(negedge clk); nxt();
    @(negedge clk);
    chk2("bp_a_beat3_busy", busy_m, busy_l, 1);
    nxt();
    @(negedge clk);
    chk2("bp_b_held_put", put_m, put_l, 0);
    chk2("bp_b_held_busy", busy_m, busy_l, 0);
    chk2("bp_b_held_count", cnt_m, cnt_l, 1);
    nxt();
    @(negedge clk); nxt();
    free_out = 1'b1;
    repeat (6) begin @(negedge clk); nxt(); end
    @(negedge clk);
    chk2("bp_b_done_count", cnt_m, cnt_l, 0);
    chk2("bp_b_done_put", put_m, put_l, 0);
    nxt();

    // back-to-back: 8 contiguous put cycles
    free_out = 1'b0;
    offer(32'hC0C1C2C3, 1'b1);
    offer(32'hD4D5D6D7, 1'b1);
    pkt_in_avail = 1'b0;
    free_out = 1'b1;
    @(negedge clk); nxt();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk2("b2b_put", put_m, put_l, 1);
      nxt();
    end
    @(negedge clk);
    chk2("b2b_end_put", put_m, put_l, 0);
    chk2("b2b_end_count", cnt_m, cnt_l, 0);
    nxt();

    // full queue
    free_out = 1'b0;
    fp[0] = 32'h01020304; fp[1] = 32'h11121314; fp[2] = 32'h21222324;
    fp[3] = 32'h31323334; fp[4] = 32'h41424344; fp[5] = 32'h51525354;
    for (int i = 0; i < 4; i++) offer(fp[i], 1'b1);
    for (int i = 0; i < 2; i++) begin
      pkt_in = fp[4]; pkt_in_avail = 1'b1;
      @(negedge clk);
      chk2("full_read", read_m, read_l, 0);
      chk2("full_count", cnt_m, cnt_l, 4);
      nxt();
    end
    free_out = 1'b1;
    @(negedge clk);
    chk2("full_pop_read", read_m, read_l, 0);
    nxt();
    @(negedge clk);
    chk2("after_pop_count", cnt_m, cnt_l, 3);
    nxt();
    pkt_in = fp[4];
    expect_pkt(fp[4]);
    #0;
    // the accept above happened at the edge just taken; fp[5] waits for the next pop
    for (int i = 0; i < 3; i++) offer(fp[5], 1'b0);
    offer(fp[5], 1'b1);
    pkt_in_avail = 1'b0;
    repeat (24) begin @(negedge clk); nxt(); end
    @(negedge clk);
    chk2("drain_count", cnt_m, cnt_l, 0);
    chk2("drain_put", put_m, put_l, 0);
    nxt();

    // reset mid-packet after beat 2, two packets still queued
    free_out = 1'b0;
    offer(32'hE1E2E3E4, 1'b1);
    offer(32'hF1F2F3F4, 1'b1);
    offer(32'h60616263, 1'b1);
    pkt_in_avail = 1'b0;
    free_out = 1'b1;
    @(negedge clk); nxt();
    @(negedge clk); nxt();
    @(negedge clk); nxt();
    @(negedge clk);
    #1;
    q_m.delete(); q_l.delete();
    rst_b = 1'b1; pkt_in_avail = 1'b1;
    #1;
    chk2("mid_rst_put", put_m, put_l, 0);
    chk2("mid_rst_payload", pay_m, pay_l, 0);
    chk2("mid_rst_busy", busy_m, busy_l, 0);
    chk2("mid_rst_count", cnt_m, cnt_l, 0);
    chk2("mid_rst_read", read_m, read_l, 0);
    pkt_in_avail = 1'b0;
    @(posedge clk); #2;
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk2("post_rst_put", put_m, put_l, 0);
      chk2("post_rst_count", cnt_m, cnt_l, 0);
      nxt();
    end
    offer(32'h9ABCDEF0, 1'b1);
    pkt_in_avail = 1'b0;
    repeat (7) begin @(negedge clk); nxt(); end
    chk("sb_empty_msb", q_m.size(), 0);
    chk("sb_empty_lsb", q_l.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
